multicycle_control_unit: RTL and testbench

- Next-generation main control for the MIPS datapath. Replaces the single-cycle, registered opcode decoder with a multi-cycle Moore FSM.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Waits on a memory ready handshake, with an optional timeout.
- Flags illegal opcodes and counts retired instructions.
- Sits between the instruction register opcode field and the shared datapath muxes, ALU control, register file and unified memory.

---
 rtl/multicycle_control_unit.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle Moore control FSM for the MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing with a memory-ready handshake, optional wait timeout and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int ALU_OP_W    = 2,
    parameter int CNT_W       = 32,
    parameter int EN_JUMP     = 1,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          instr_op,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic                mem_timeout,
    output logic                retire,
    output logic [CNT_W-1:0]    retire_count,
    output logic [3:0]          state_out
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = '0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(2);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic                memRead;
        logic                iord;
        logic                memWrite;
        logic                memToReg;
        logic                regDst;
        logic                regWrite;
        logic                aluSrcA;
        logic [1:0]          aluSrcB;
        logic [ALU_OP_W-1:0] aluOp;
        logic [1:0]          pcSource;
        logic                pcWriteCond;
        logic                pcWriteJump;
        logic                fetch;
        logic                memWr;
        logic                retireFixed;
    } ctrl_t;

    state_t            state_q, state_d;
    ctrl_t             ctrl_q;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [CNT_W-1:0]  retireCount_q;
    logic              memWait;
    logic              timeoutHit;
    logic              illegalOp;

    // Moore decode of a state; registered from the next state so outputs line up with state_q.
    function automatic ctrl_t decodeCtrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.memRead = 1'b1; c.aluSrcB = 2'd1; c.fetch = 1'b1; end
            S_DECODE:   begin c.aluSrcB = 2'd3; end
            S_MEM_ADDR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; end
            S_MEM_RD:   begin c.memRead = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:   begin c.regWrite = 1'b1; c.memToReg = 1'b1; c.retireFixed = 1'b1; end
            S_MEM_WR:   begin c.memWrite = 1'b1; c.iord = 1'b1; c.memWr = 1'b1; end
            S_EXEC:     begin c.aluSrcA = 1'b1; c.aluOp = ALU_FUNCT; end
            S_R_WB:     begin c.regWrite = 1'b1; c.regDst = 1'b1; c.retireFixed = 1'b1; end
            S_BRANCH:   begin
                c.aluSrcA = 1'b1; c.aluOp = ALU_SUB; c.pcWriteCond = 1'b1;
                c.pcSource = 2'd1; c.retireFixed = 1'b1;
            end
            S_ADDI_EX:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; c.aluOp = ALU_ADD; end
            S_ADDI_WB:  begin c.regWrite = 1'b1; c.retireFixed = 1'b1; end
            S_JUMP:     begin c.pcWriteJump = 1'b1; c.pcSource = 2'd2; c.retireFixed = 1'b1; end
            default:    ;
        endcase
        return c;
    endfunction

    assign memWait    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeoutHit = (MEM_TIMEOUT > 0) && memWait && !mem_ready && (waitCnt_q == WAIT_LAST);

    always_comb begin
        state_d   = state_q;
        illegalOp = 1'b0;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (instr_op)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J: begin
                        if (EN_JUMP != 0) begin
                            state_d = S_JUMP;
                        end else begin
                            state_d   = S_FETCH;
                            illegalOp = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = S_FETCH;
                        illegalOp = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (instr_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)       state_d = S_MEM_WB;
                else if (timeoutHit) state_d = S_FETCH;
            end
            S_MEM_WR:   if (mem_ready || timeoutHit) state_d = S_FETCH;
            S_EXEC:     state_d = S_R_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            default:    state_d = S_FETCH;
        endcase

        // A timeout re-enters FETCH, so it restarts the count like any other state entry.
        waitCnt_d = '0;
        if ((state_d == state_q) && memWait && !mem_ready && !timeoutHit) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            ctrl_q        <= decodeCtrl(S_FETCH);
            waitCnt_q     <= '0;
            retireCount_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= decodeCtrl(state_d);
            waitCnt_q <= waitCnt_d;
            if (retire) retireCount_q <= retireCount_q + 1'b1;
        end
    end

    assign ir_write      = !rst && ctrl_q.fetch && mem_ready;
    assign pc_write      = ctrl_q.pcWriteJump || (!rst && ctrl_q.fetch && mem_ready);
    assign pc_write_cond = ctrl_q.pcWriteCond;
    assign iord          = ctrl_q.iord;
    assign mem_read      = ctrl_q.memRead;
    assign mem_write     = ctrl_q.memWrite;
    assign mem_to_reg    = ctrl_q.memToReg;
    assign reg_dst       = ctrl_q.regDst;
    assign reg_write     = ctrl_q.regWrite;
    assign alu_src_a     = ctrl_q.aluSrcA;
    assign alu_src_b     = ctrl_q.aluSrcB;
    assign alu_op        = ctrl_q.aluOp;
    assign pc_source     = ctrl_q.pcSource;
    assign retire        = !rst && (ctrl_q.retireFixed || (ctrl_q.memWr && mem_ready));
    assign illegal_op    = !rst && illegalOp;
    assign mem_timeout   = !rst && timeoutHit;
    assign retire_count  = retireCount_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one default instance (A) and one with
// EN_JUMP=0, MEM_TIMEOUT=4, CNT_W=3 (B).
module tb_multicycle_control_unit;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   logic clk = 1'b0;
   int compared   = 0;
   int mismatched = 0;

   logic rstA, readyA;
   logic [5:0] opA;
   logic pcWriteA, pcWriteCondA, iordA, memReadA, memWriteA, irWriteA, memToRegA, regDstA, regWriteA, aluSrcAA;
   logic [1:0] aluSrcBA, aluOpA, pcSourceA;
   logic illegalA, timeoutA, retireA;
   logic [31:0] countA;
   logic [3:0] stateA;

   logic rstB, readyB;
   logic [5:0] opB;
   logic pcWriteB, pcWriteCondB, iordB, memReadB, memWriteB, irWriteB, memToRegB, regDstB, regWriteB, aluSrcAB;
   logic [1:0] aluSrcBB, aluOpB, pcSourceB;
   logic illegalB, timeoutB, retireB;
   logic [2:0] countB;
   logic [3:0] stateB;

   always #5 clk = ~clk;

   multicycle_control_unit dutA (
      .clk(clk), .rst(rstA), .instr_op(opA), .mem_ready(readyA),
      .pc_write(pcWriteA), .pc_write_cond(pcWriteCondA), .iord(iordA), .mem_read(memReadA),
      .mem_write(memWriteA), .ir_write(irWriteA), .mem_to_reg(memToRegA), .reg_dst(regDstA),
      .reg_write(regWriteA), .alu_src_a(aluSrcAA), .alu_src_b(aluSrcBA), .alu_op(aluOpA),
      .pc_source(pcSourceA), .illegal_op(illegalA), .mem_timeout(timeoutA), .retire(retireA),
      .retire_count(countA), .state_out(stateA)
   );

   multicycle_control_unit #(.ALU_OP_W(2), .CNT_W(3), .EN_JUMP(0), .MEM_TIMEOUT(4)) dutB (
      .clk(clk), .rst(rstB), .instr_op(opB), .mem_ready(readyB),
      .pc_write(pcWriteB), .pc_write_cond(pcWriteCondB), .iord(iordB), .mem_read(memReadB),
      .mem_write(memWriteB), .ir_write(irWriteB), .mem_to_reg(memToRegB), .reg_dst(regDstB),
      .reg_write(regWriteB), .alu_src_a(aluSrcAB), .alu_src_b(aluSrcBB), .alu_op(aluOpB),
      .pc_source(pcSourceB), .illegal_op(illegalB), .mem_timeout(timeoutB), .retire(retireB),
      .retire_count(countB), .state_out(stateB)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rstA = 1'b1; readyA = 1'b1; opA = OP_LW;
      rstB = 1'b1; readyB = 1'b0; opB = OP_R;
      tick; tick;
      @(negedge clk);
      compared++;
      if (stateA !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_stateA: got %0d expected 0", stateA); end
      compared++;
      if (countA !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_countA: got %0d expected 0", countA); end
      compared++;
      if ({retireA, illegalA, timeoutA} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_pulsesA: got %b expected 000", {retireA, illegalA, timeoutA}); end
      compared++;
      if (stateB !== 4'd0 || countB !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_B: got state %0d count %0d expected 0/0", stateB, countB); end
      tick;
      rstA = 1'b0; rstB = 1'b0;
   endtask

   task automatic test_lw;
      int expSt[5] = '{0, 1, 2, 3, 4};
      opA = OP_LW; readyA = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         compared++;
         if (stateA !== 4'(expSt[i])) begin mismatched++; $display("[TB] FAIL lw_state[%0d]: got %0d expected %0d", i, stateA, expSt[i]); end
         compared++;
         if (regWriteA !== (i == 4) || memToRegA !== (i == 4)) begin
            mismatched++; $display("[TB] FAIL lw_wb[%0d]: got reg_write %b mem_to_reg %b expected %b", i, regWriteA, memToRegA, (i == 4));
         end
         compared++;
         if (retireA !== (i == 4)) begin mismatched++; $display("[TB] FAIL lw_retire[%0d]: got %b expected %b", i, retireA, (i == 4)); end
         if (i == 1) begin
            compared++;
            if (aluSrcBA !== 2'd3 || aluOpA !== 2'd0) begin mismatched++; $display("[TB] FAIL lw_decode_alu: got srcb %0d op %0d expected 3/0", aluSrcBA, aluOpA); end
         end
         if (i == 3) begin
            compared++;
            if (memReadA !== 1'b1 || iordA !== 1'b1) begin mismatched++; $display("[TB] FAIL lw_memrd: got mem_read %b iord %b expected 1/1", memReadA, iordA); end
         end
         tick;
      end
      readyA = 1'b0;
      @(negedge clk);
      compared++;
      if (countA !== 32'd1 || stateA !== 4'd0) begin mismatched++; $display("[TB] FAIL lw_done: got count %0d state %0d expected 1/0", countA, stateA); end
      tick;
   endtask

   task automatic test_back_to_back;
      logic [5:0] ops[5] = '{OP_R, OP_SW, OP_ADDI, OP_BEQ, OP_J};
      int cpi[5] = '{4, 4, 4, 3, 3};
      int cyc;
      bit done;
      readyA = 1'b1;
      for (int k = 0; k < 5; k++) begin
         opA = ops[k]; cyc = 0; done = 0;
         while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (stateA == 4'd8) begin
               compared++;
               if (pcWriteCondA !== 1'b1 || pcSourceA !== 2'd1 || aluOpA !== 2'd1) begin
                  mismatched++; $display("[TB] FAIL b2b_branch: got pwc %b src %0d op %0d expected 1/1/1", pcWriteCondA, pcSourceA, aluOpA);
               end
            end else begin
               compared++;
               if (pcWriteCondA !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_pwc_state%0d: got %b expected 0", stateA, pcWriteCondA); end
            end
            if (stateA == 4'd11) begin
               compared++;
               if (pcSourceA !== 2'd2 || pcWriteA !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_jump: got src %0d pcw %b expected 2/1", pcSourceA, pcWriteA); end
            end
            if (stateA == 4'd6) begin
               compared++;
               if (aluOpA !== 2'd2 || aluSrcAA !== 1'b1 || aluSrcBA !== 2'd0) begin
                  mismatched++; $display("[TB] FAIL b2b_exec: got op %0d srca %b srcb %0d expected 2/1/0", aluOpA, aluSrcAA, aluSrcBA);
               end
            end
            if (retireA) done = 1;
            tick;
         end
         compared++;
         if (cyc !== cpi[k] || !done) begin mismatched++; $display("[TB] FAIL b2b_cpi[%0d]: got %0d expected %0d", k, cyc, cpi[k]); end
      end
      readyA = 1'b0;
      @(negedge clk);
      compared++;
      if (countA !== 32'd6) begin mismatched++; $display("[TB] FAIL b2b_count: got %0d expected 6", countA); end
      tick;
   endtask

   task automatic test_sw_wait;
      int nWr = 0;
      int nRet = 0;
      int retCyc = -1;
      opA = OP_SW; readyA = 1'b1;
      tick; tick; tick;
      readyA = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) readyA = 1'b1;
         @(negedge clk);
         if (i == 0) begin
            compared++;
            if (stateA !== 4'd5) begin mismatched++; $display("[TB] FAIL sw_state: got %0d expected 5", stateA); end
         end
         if (memWriteA) nWr++;
         if (retireA) begin nRet++; retCyc = i; end
         tick;
      end
      compared++;
      if (nWr !== 4) begin mismatched++; $display("[TB] FAIL sw_memwrite_cycles: got %0d expected 4", nWr); end
      compared++;
      if (nRet !== 1 || retCyc !== 3) begin mismatched++; $display("[TB] FAIL sw_retire: got %0d pulses at %0d expected 1 at 3", nRet, retCyc); end
      readyA = 1'b0;
      @(negedge clk);
      compared++;
      if (stateA !== 4'd0 || countA !== 32'd7) begin mismatched++; $display("[TB] FAIL sw_done: got state %0d count %0d expected 0/7", stateA, countA); end
      tick;
   endtask

   task automatic test_illegal;
      opA = 6'b111111; readyA = 1'b1;
      tick;
      readyA = 1'b0;
      @(negedge clk);
      compared++;
      if (stateA !== 4'd1 || illegalA !== 1'b1 || retireA !== 1'b0) begin
         mismatched++; $display("[TB] FAIL illegalA_decode: got state %0d ill %b ret %b expected 1/1/0", stateA, illegalA, retireA);
      end
      tick;
      @(negedge clk);
      compared++;
      if (stateA !== 4'd0 || illegalA !== 1'b0 || countA !== 32'd7) begin
         mismatched++; $display("[TB] FAIL illegalA_after: got state %0d ill %b count %0d expected 0/0/7", stateA, illegalA, countA);
      end
      tick;
      opB = OP_J; readyB = 1'b1;
      tick;
      readyB = 1'b0;
      @(negedge clk);
      compared++;
      if (stateB !== 4'd1 || illegalB !== 1'b1) begin mismatched++; $display("[TB] FAIL illegalB_jump: got state %0d ill %b expected 1/1", stateB, illegalB); end
      tick;
      @(negedge clk);
      compared++;
      if (stateB !== 4'd0 || countB !== 3'd0) begin mismatched++; $display("[TB] FAIL illegalB_after: got state %0d count %0d expected 0/0", stateB, countB); end
      tick;
   endtask

   task automatic test_timeout;
      rstB = 1'b1; opB = OP_R;
      tick;
      rstB = 1'b0; readyB = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         compared++;
         if (timeoutB !== (i == 3) || irWriteB !== 1'b0 || stateB !== 4'd0) begin
            mismatched++; $display("[TB] FAIL timeout_wait[%0d]: got to %b irw %b state %0d expected %b/0/0", i, timeoutB, irWriteB, stateB, (i == 3));
         end
         tick;
      end
      readyB = 1'b1;
      @(negedge clk);
      compared++;
      if (timeoutB !== 1'b0 || irWriteB !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_ready_wins: got to %b irw %b expected 0/1", timeoutB, irWriteB); end
      tick;
      readyB = 1'b0;
      @(negedge clk);
      compared++;
      if (stateB !== 4'd1) begin mismatched++; $display("[TB] FAIL timeout_decode: got %0d expected 1", stateB); end
      tick; tick; tick;
      @(negedge clk);
      compared++;
      if (stateB !== 4'd0 || countB !== 3'd1) begin mismatched++; $display("[TB] FAIL timeout_r_done: got state %0d count %0d expected 0/1", stateB, countB); end
      tick;
   endtask

   task automatic test_reset_mid_wait;
      opA = OP_LW; readyA = 1'b1;
      tick; tick; tick;
      readyA = 1'b0;
      @(negedge clk);
      compared++;
      if (stateA !== 4'd3) begin mismatched++; $display("[TB] FAIL midwait_state: got %0d expected 3", stateA); end
      tick;
      rstA = 1'b1;
      tick;
      @(negedge clk);
      compared++;
      if (stateA !== 4'd0 || countA !== 32'd0 || retireA !== 1'b0) begin
         mismatched++; $display("[TB] FAIL midwait_reset: got state %0d count %0d ret %b expected 0/0/0", stateA, countA, retireA);
      end
      rstA = 1'b0;
      tick;
   endtask

   task automatic test_wrap;
      rstB = 1'b1;
      tick;
      rstB = 1'b0; opB = OP_R; readyB = 1'b1;
      for (int c = 0; c < 32; c++) begin
         tick;
         if (c == 27) begin
            @(negedge clk);
            compared++;
            if (countB !== 3'd7) begin mismatched++; $display("[TB] FAIL wrap_seven: got %0d expected 7", countB); end
         end
      end
      @(negedge clk);
      compared++;
      if (countB !== 3'd0 || stateB !== 4'd0) begin mismatched++; $display("[TB] FAIL wrap_zero: got count %0d state %0d expected 0/0", countB, stateB); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset;
      test_lw;
      test_back_to_back;
      test_sw_wait;
      test_illegal;
      test_timeout;
      test_reset_mid_wait;
      test_wrap;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
